alfsr_stream_checker: RTL and testbench

Receive-side checker for the ALFSR serial bitstream. It self-synchronises a local Fibonacci LFSR to the incoming bits, declares lock after a run of correct predictions, then counts bit errors against the flywheel prediction. Sits after the digitalised RNG output (or an external copy of it) to qualify the generator on-chip.

---
 rtl/alfsr_stream_checker_if.sv | 23 ++
 rtl/alfsr_stream_checker.sv | 134 +++++++++++++
 tb/tb_alfsr_stream_checker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alfsr_stream_checker_if.sv
// Handshake bundle between an ALFSR bit source and the stream checker.
// The source drives the bit stream; the checker returns lock and error status.
interface alfsr_stream_checker_if #(
  parameter int ERR_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state_out;

  modport master (
    output bit_in, bit_valid, clr_err,
    input  locked, err_pulse, err_count, state_out
  );

  modport slave (
    input  bit_in, bit_valid, clr_err,
    output locked, err_pulse, err_count, state_out
  );
endinterface

// File: rtl/alfsr_stream_checker.sv
// Self-synchronising Fibonacci LFSR checker: seeds from the stream,
// verifies predictions, then flywheels and counts bit errors.
module alfsr_stream_checker #(
  parameter int             WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
  parameter int             LOCK_THRESH = 16,
  parameter int             LOSS_THRESH = 4,
  parameter int             ERR_W       = 16
) (
  input  logic clk,
  input  logic rst,
  alfsr_stream_checker_if.slave bus
);

  localparam int SEED_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [SEED_W-1:0]  seed_cnt, seed_n;
  logic [MATCH_W-1:0] match_cnt, match_n;
  logic [MISS_W-1:0]  miss_cnt, miss_n;
  logic               err_pulse, pulse_n;
  logic [ERR_W-1:0]   err_count, errc_n;

  logic               pred;
  logic [WIDTH-1:0]   sh_in;
  logic [WIDTH-1:0]   sh_fly;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;

  assign pred      = ^(sreg & TAPS);
  assign sh_in     = {sreg[WIDTH-2:0], bus.bit_in};
  assign sh_fly    = {sreg[WIDTH-2:0], pred};
  assign match_inc = match_cnt + MATCH_W'(1);
  assign miss_inc  = miss_cnt + MISS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      sreg      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      seed_cnt  <= seed_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_pulse <= pulse_n;
      err_count <= errc_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    seed_n  = seed_cnt;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    pulse_n = 1'b0;
    errc_n  = err_count;
    if (bus.bit_valid) begin
      unique case (state)
        SEED: begin
          sreg_n = sh_in;
          if (seed_cnt == SEED_W'(WIDTH - 1)) begin
            seed_n = '0;
            // an all-zero register would predict zeros forever
            if (sh_in != '0) begin
              state_n = VERIFY;
              match_n = '0;
            end
          end else begin
            seed_n = seed_cnt + SEED_W'(1);
          end
        end
        VERIFY: begin
          sreg_n = sh_in;
          if (bus.bit_in == pred) begin
            match_n = match_inc;
            if (match_inc == MATCH_W'(LOCK_THRESH)) begin
              state_n = LOCKED;
              match_n = '0;
              miss_n  = '0;
            end
          end else begin
            state_n = SEED;
            seed_n  = '0;
          end
        end
        LOCKED: begin
          // flywheel: the register runs on its own prediction
          sreg_n = sh_fly;
          if (bus.bit_in != pred) begin
            pulse_n = 1'b1;
            if (err_count != '1)
              errc_n = err_count + ERR_W'(1);
            miss_n = miss_inc;
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              state_n = SEED;
              seed_n  = '0;
              miss_n  = '0;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: begin
          state_n = SEED;
          seed_n  = '0;
        end
      endcase
    end
    if (bus.clr_err)
      errc_n = '0;
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.state_out = state;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_alfsr_stream_checker.sv
// Directed bench for alfsr_stream_checker: vector table plus
// hand-written seeding, gap and reset sequences.
module tb_alfsr_stream_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alfsr_stream_checker_if #(.ERR_W(16)) ifc ();
  alfsr_stream_checker_if #(.ERR_W(4))  ifc2 ();

  assign ifc2.bit_in    = ifc.bit_in;
  assign ifc2.bit_valid = ifc.bit_valid;
  assign ifc2.clr_err   = ifc.clr_err;

  alfsr_stream_checker #(
    .WIDTH(8), .TAPS(8'hB8), .LOCK_THRESH(16),
    .LOSS_THRESH(4), .ERR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  alfsr_stream_checker #(
    .WIDTH(8), .TAPS(8'hB8), .LOCK_THRESH(16),
    .LOSS_THRESH(4), .ERR_W(4)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(ifc2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] g;

  typedef struct {
    string name;
    int    pat;
    bit    valid;
    bit    clr;
    int    rep;
    int    e_state;
    int    e_locked;
    int    e_pulse;
    int    e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    b = ^(g & 8'hB8);
    g = {g[6:0], b};
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    ifc.bit_in    = b;
    ifc.bit_valid = v;
    ifc.clr_err   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g = 8'h01;
  endtask

  task automatic check_all(input string nm, input int st, input int lk,
                           input int pu, input int er);
    check({nm, ".state"}, int'(ifc.state_out), st);
    check({nm, ".locked"}, int'(ifc.locked), lk);
    check({nm, ".pulse"}, int'(ifc.err_pulse), pu);
    check({nm, ".err"}, int'(ifc.err_count), er);
    check({nm, ".err4"}, int'(ifc2.err_count), (er > 15) ? 15 : er);
  endtask

  function automatic vec_t mk(string nm, int pat, bit v, bit c, int rep,
                              int st, int lk, int pu, int er);
    vec_t r;
    r.name = nm; r.pat = pat; r.valid = v; r.clr = c; r.rep = rep;
    r.e_state = st; r.e_locked = lk; r.e_pulse = pu; r.e_err = er;
    return r;
  endfunction

  initial begin
    logic b;
    int nv;
    ifc.bit_in = 1'b0;
    ifc.bit_valid = 1'b0;
    ifc.clr_err = 1'b0;

    // pat: 0 clean, 1 every bit inverted, 2 alternate starting inverted
    tbl.push_back(mk("seed7",     0, 1, 0,   7, 0, 0, 0, 0));
    tbl.push_back(mk("seed8",     0, 1, 0,   1, 1, 0, 0, 0));
    tbl.push_back(mk("verify15",  0, 1, 0,  15, 1, 0, 0, 0));
    tbl.push_back(mk("lock24",    0, 1, 0,   1, 2, 1, 0, 0));
    tbl.push_back(mk("clean1000", 0, 1, 0, 976, 2, 1, 0, 0));
    tbl.push_back(mk("single_err",1, 1, 0,   1, 2, 1, 1, 1));
    tbl.push_back(mk("flywheel",  0, 1, 0,  20, 2, 1, 0, 1));
    tbl.push_back(mk("clr",       0, 1, 1,   1, 2, 1, 0, 0));
    tbl.push_back(mk("miss3",     1, 1, 0,   3, 2, 1, 1, 3));
    tbl.push_back(mk("miss4",     1, 1, 0,   1, 0, 0, 1, 4));
    tbl.push_back(mk("reseed7",   0, 1, 0,   7, 0, 0, 0, 4));
    tbl.push_back(mk("reseed8",   0, 1, 0,   1, 1, 0, 0, 4));
    tbl.push_back(mk("reverify",  0, 1, 0,  15, 1, 0, 0, 4));
    tbl.push_back(mk("relock",    0, 1, 0,   1, 2, 1, 0, 4));
    tbl.push_back(mk("sat20",     2, 1, 0,  40, 2, 1, 0, 24));
    tbl.push_back(mk("gap",       0, 0, 0,   5, 2, 1, 0, 24));
    tbl.push_back(mk("clr_vs_err",1, 1, 1,   1, 2, 1, 1, 0));
    tbl.push_back(mk("pulse_once",0, 1, 0,   1, 2, 1, 0, 0));

    do_reset();
    check_all("reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        if (tbl[i].valid) begin
          gen_bit(b);
          if (tbl[i].pat == 1 || (tbl[i].pat == 2 && k % 2 == 0))
            b = ~b;
          send(b, 1'b1, tbl[i].clr);
        end else begin
          send(1'($urandom_range(0, 1)), 1'b0, tbl[i].clr);
        end
      end
      check_all(tbl[i].name, tbl[i].e_state, tbl[i].e_locked,
                tbl[i].e_pulse, tbl[i].e_err);
    end

    // reset while locked with a nonzero error count
    gen_bit(b);
    send(~b, 1'b1, 1'b0);
    check("pre_rst.err", int'(ifc.err_count), 1);
    rst = 1'b1;
    gen_bit(b);
    send(~b, 1'b1, 1'b0);
    rst = 1'b0;
    check_all("rst_locked", 0, 0, 0, 0);

    // all-zero seed is rejected, then VERIFY fails on bit 5
    do_reset();
    for (int k = 0; k < 8; k++) send(1'b0, 1'b1, 1'b0);
    check_all("zero_seed", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0);
    end
    check_all("good_seed", 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0);
    end
    check_all("verify4", 1, 0, 0, 0);
    gen_bit(b);
    send(~b, 1'b1, 1'b0);
    check_all("verify_fail", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      gen_bit(b);
      send(b, 1'b1, 1'b0);
    end
    check_all("post_fail_seed", 1, 0, 0, 0);

    // random bit_valid gaps: lock lands on the 24th valid bit
    do_reset();
    nv = 0;
    for (int cyc = 0; cyc < 400 && nv < 24; cyc++) begin
      if ($urandom_range(0, 2) == 0) begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end else begin
        gen_bit(b);
        send(b, 1'b1, 1'b0);
        nv++;
        if (nv == 23) check_all("gaps23", 1, 0, 0, 0);
      end
    end
    check("gaps.count", nv, 24);
    check_all("gaps24", 2, 1, 0, 0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    check_all("gaps_idle", 2, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
